uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter core between two byte-stream requesters, e.g. the button-triggered message generator and the RX echo path.
- Arbitrates at message granularity: a grant is held from the first byte through the byte flagged last, so messages never interleave.
- Sequences the transmitter's start/busy handshake and inserts a programmable idle gap between messages.
- Sits between the requesters and the UART TX core inside the UART interface top level.

Parameters:
- DATA_W, 8, byte width of request data and tx_data.
- MAX_MSG_LEN, 64, maximum bytes per grant; reaching it forces message end.
- GAP_CYCLES, 16, idle clock cycles inserted after each message (0 allowed).

Ports:
- clk_100mhz  in  1  system clock.
- sys_rst_i  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a byte.
- req0_data  in  DATA_W  requester 0 byte.
- req0_last  in  1  byte is final byte of message.
- req0_ready  out  1  byte accepted when valid&ready.
- req1_valid, req1_data, req1_last, req1_ready: same as req0, for requester 1.
- tx_start  out  1  one-cycle pulse; TX core latches tx_data.
- tx_data  out  DATA_W  byte to transmit; held until next start.
- tx_busy  in  1  TX core busy; high from cycle after tx_start until stop bit done.
- grant  out  2  one-hot current owner; 00 when none.
- overrun_o  out  1  sticky; a message was truncated by MAX_MSG_LEN.

Behaviour:
- Reset (async assert, sync release): state=IDLE; grant=00; tx_start=0; tx_data=0; readies=0; overrun_o=0; byte_cnt=0; gap_cnt=0; last_grant=1, so req0 wins the first tie.
- States: IDLE, LOAD, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - If exactly one reqN_valid: grant=N, registered, and enter LOAD next cycle.
  - If both valid: grant the requester != last_grant.
  - byte_cnt cleared on grant.
- LOAD:
  - reqN_ready=1 for the granted requester only, combinationally gated by state==LOAD and tx_busy==0.
  - On valid&ready: capture the byte into tx_data, pulse tx_start the next cycle, and increment byte_cnt.
  - Capture last flag as msg_end = reqN_last OR (byte_cnt+1 == MAX_MSG_LEN).
  - If truncated (length hit without last): set overrun_o.
  - Go to WAIT_BUSY.
  - If the granted valid is low, remain in LOAD with the grant locked; no timeout.
- WAIT_BUSY: wait for tx_busy=1, then go to WAIT_DONE.
- WAIT_DONE: on tx_busy=0, go to GAP if msg_end, else back to LOAD.
- Accepted byte to tx_start latency: exactly 1 cycle.
- IDLE valid to first ready: 1 cycle, provided tx_busy=0.
- Readiness: ready never asserts outside LOAD; at most one accept per tx_start.
- GAP:
  - grant=00 and last_grant updated.
  - Count GAP_CYCLES cycles, then go to IDLE.
  - GAP_CYCLES=0 means IDLE on the next cycle.
- Truncated message: bytes remaining after truncation are arbitrated as a new message.
- byte_cnt width: clog2(MAX_MSG_LEN+1); no wrap, because it is cleared on every grant.
- Non-granted requester's valid: ignored until IDLE; its ready stays 0.
- Reset mid-operation: all outputs return to reset values immediately. The byte in flight in the TX core is not aborted by this block; after release, new grants wait in LOAD until tx_busy=0.
- overrun_o clears only on reset.

Test Plan:
- req0 message 0x48,0x69,0x0A (last on 0x0A); TX model busy 10 cycles -> grant=01; three tx_start pulses with tx_data 0x48,0x69,0x0A in order; req1_ready stays 0; 16 idle cycles with grant=00 before IDLE.
- Both valid in the same cycle after reset -> req0 message completes first, then req1; both valid again -> req0 granted (alternation).
- req1_valid rises during byte 2 of a 3-byte req0 message -> no req1 byte is transmitted before req0's last byte plus 16 gap cycles.
- MAX_MSG_LEN=4, req1 sends 6 bytes, last only on byte 6:
  - overrun_o=1 after byte 4, then gap.
  - Bytes 5-6 are sent under a new grant.
  - overrun_o stays 1.
- sys_rst_i pulsed during WAIT_DONE -> tx_start, grant, readies and overrun_o are 0 within the same cycle. After release, with tx_busy still high, a new req0 request gets no ready until tx_busy=0.
- GAP_CYCLES=0, back-to-back req0 messages -> the second message's grant appears 2 cycles after the first message's tx_busy falls.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Message-granular arbiter sharing one UART TX core between two byte-stream requesters.
// Holds a grant from first byte to last byte, sequences start/busy, and inserts an idle gap.
module uart_tx_arbiter #(
    parameter int DATA_W      = 8,
    parameter int MAX_MSG_LEN = 64,
    parameter int GAP_CYCLES  = 16
) (
    input  logic              clk_100mhz,
    input  logic              sys_rst_i,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_last,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_last,
    output logic              req1_ready,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_busy,
    output logic [1:0]        grant,
    output logic              overrun_o
);

    localparam int CNT_W = $clog2(MAX_MSG_LEN + 1);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_MSG_LEN);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  byte_cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [GAP_W-1:0]  gap_cnt;
    logic              last_grant;
    logic              msg_end;

    logic              sel_valid;
    logic [DATA_W-1:0] sel_data;
    logic              sel_last;
    logic              ready_en;
    logic              accept;
    logic              hit_max;
    logic              gap_done;
    logic              msg_done;
    logic [1:0]        pick;

    // The granted requester's byte stream is the only one the datapath ever sees.
    assign sel_valid = grant[1] ? req1_valid : req0_valid;
    assign sel_data  = grant[1] ? req1_data  : req0_data;
    assign sel_last  = grant[1] ? req1_last  : req0_last;

    // Valid/ready: a byte moves when valid and ready are both high at a rising clock edge;
    // ready depends only on state, grant and tx_busy, never on valid.
    assign ready_en   = (state == S_LOAD) && !tx_busy;
    assign req0_ready = ready_en && grant[0];
    assign req1_ready = ready_en && grant[1];
    assign accept     = ready_en && (grant != 2'b00) && sel_valid;

    assign cnt_next = byte_cnt + 1'b1;
    assign hit_max  = (cnt_next == CNT_MAX);
    assign gap_done = (gap_cnt == GAP_LAST);
    assign msg_done = (state == S_WAIT_DONE) && !tx_busy && msg_end;

    always_ff @(posedge clk_100mhz or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pick       = 2'b00;
        case (state)
            S_IDLE: begin
                // On a tie, last_grant names the requester served most recently.
                if (req0_valid && req1_valid) begin
                    pick = last_grant ? 2'b01 : 2'b10;
                end else if (req0_valid) begin
                    pick = 2'b01;
                end else if (req1_valid) begin
                    pick = 2'b10;
                end
                if (pick != 2'b00) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    state_next = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (!msg_end) begin
                        state_next = S_LOAD;
                    end else if (GAP_CYCLES == 0) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_done) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100mhz or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            grant      <= 2'b00;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            overrun_o  <= 1'b0;
            byte_cnt   <= '0;
            gap_cnt    <= '0;
            last_grant <= 1'b1;
            msg_end    <= 1'b0;
        end else begin
            tx_start <= accept;
            if ((state == S_IDLE) && (pick != 2'b00)) begin
                grant    <= pick;
                byte_cnt <= '0;
            end
            if (accept) begin
                tx_data  <= sel_data;
                byte_cnt <= cnt_next;
                msg_end  <= sel_last || hit_max;
                if (hit_max && !sel_last) begin
                    overrun_o <= 1'b1;
                end
            end
            // Grant is dropped as the message ends, so GAP and IDLE both show 00.
            if (msg_done) begin
                grant      <= 2'b00;
                last_grant <= grant[1];
            end
            if (state == S_GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: three instances (default, MAX_MSG_LEN=4, GAP_CYCLES=0),
// queue-fed requesters, a TX core model with a 10-cycle busy, and a table of expected bytes.
module tb_uart_tx_arbiter;

    localparam int BUSY_LEN = 10;

    typedef struct packed {
        logic [31:0] cyc;
        logic        ovr;
        logic [1:0]  gnt;
        logic [7:0]  data;
    } rec_t;

    typedef struct packed {
        logic [1:0] inst;
        logic [7:0] data;
        logic [1:0] gnt;
        logic       ovr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   bad_ready = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    logic       req_valid [3][2];
    logic [7:0] req_data  [3][2];
    logic       req_last  [3][2];
    logic       req_ready [3][2];
    logic       tx_start  [3];
    logic [7:0] tx_data   [3];
    logic       tx_busy   [3];
    logic [1:0] grant     [3];
    logic       overrun   [3];

    logic [8:0] src_q [3][2][$];
    rec_t       got_q [3][$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int MAXL = (g == 1) ? 4 : 64;
        localparam int GAPC = (g == 2) ? 0 : 16;

        uart_tx_arbiter #(.DATA_W(8), .MAX_MSG_LEN(MAXL), .GAP_CYCLES(GAPC)) u_dut (
            .clk_100mhz (clk),
            .sys_rst_i  (rst),
            .req0_valid (req_valid[g][0]),
            .req0_data  (req_data[g][0]),
            .req0_last  (req_last[g][0]),
            .req0_ready (req_ready[g][0]),
            .req1_valid (req_valid[g][1]),
            .req1_data  (req_data[g][1]),
            .req1_last  (req_last[g][1]),
            .req1_ready (req_ready[g][1]),
            .tx_start   (tx_start[g]),
            .tx_data    (tx_data[g]),
            .tx_busy    (tx_busy[g]),
            .grant      (grant[g]),
            .overrun_o  (overrun[g])
        );

        // TX core model: busy rises the cycle after tx_start and lasts BUSY_LEN cycles.
        int   busy_cnt = 0;
        logic start_seen = 1'b0;

        always @(negedge clk) begin
            start_seen = tx_start[g];
            if (tx_start[g]) begin
                got_q[g].push_back({32'(cyc), overrun[g], grant[g], tx_data[g]});
            end
        end

        initial begin
            tx_busy[g] = 1'b0;
            forever begin
                @(posedge clk);
                #1;
                if (start_seen) begin
                    busy_cnt = BUSY_LEN;
                end else if (busy_cnt > 0) begin
                    busy_cnt = busy_cnt - 1;
                end
                tx_busy[g] = (busy_cnt > 0);
            end
        end

        for (genvar r = 0; r < 2; r++) begin : g_req
            logic take;
            initial begin
                req_valid[g][r] = 1'b0;
                req_data[g][r]  = 8'h00;
                req_last[g][r]  = 1'b0;
                forever begin
                    @(negedge clk);
                    take = req_valid[g][r] && req_ready[g][r];
                    @(posedge clk);
                    #1;
                    if (take) begin
                        void'(src_q[g][r].pop_front());
                    end
                    if (src_q[g][r].size() > 0) begin
                        req_valid[g][r] = 1'b1;
                        req_data[g][r]  = src_q[g][r][0][7:0];
                        req_last[g][r]  = src_q[g][r][0][8];
                    end else begin
                        req_valid[g][r] = 1'b0;
                        req_data[g][r]  = 8'h00;
                        req_last[g][r]  = 1'b0;
                    end
                end
            end
        end
    end

    // A ready may only be offered to the current owner while the TX core is idle.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (!rst && req_ready[i][r] && (!grant[i][r] || tx_busy[i])) begin
                    bad_ready = bad_ready + 1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_got(input int i, input int n, input string name);
        int t;
        t = 0;
        while (got_q[i].size() < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk(name, 32'(got_q[i].size()), 32'(n));
    endtask

    task automatic wait_busy(input int i, input logic lvl, input string name);
        int t;
        t = 0;
        while (tx_busy[i] !== lvl && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk(name, 32'(tx_busy[i]), 32'(lvl));
    endtask

    task automatic settle();
        repeat (40) @(negedge clk);
    endtask

    vec_t vecs [23];
    int   idx [3];
    int   nz;
    int   t;
    rec_t rec;

    initial begin
        // Expected transmissions per instance, in order: {inst, data, grant, overrun}.
        vecs = '{
            '{2'd0, 8'h11, 2'b01, 1'b0}, '{2'd0, 8'h12, 2'b01, 1'b0},
            '{2'd0, 8'h21, 2'b10, 1'b0}, '{2'd0, 8'h22, 2'b10, 1'b0},
            '{2'd0, 8'h31, 2'b01, 1'b0}, '{2'd0, 8'h41, 2'b10, 1'b0},
            '{2'd0, 8'h48, 2'b01, 1'b0}, '{2'd0, 8'h69, 2'b01, 1'b0},
            '{2'd0, 8'h0A, 2'b01, 1'b0}, '{2'd0, 8'h51, 2'b01, 1'b0},
            '{2'd0, 8'h52, 2'b01, 1'b0}, '{2'd0, 8'h53, 2'b01, 1'b0},
            '{2'd0, 8'h61, 2'b10, 1'b0}, '{2'd0, 8'h91, 2'b01, 1'b0},
            '{2'd0, 8'h92, 2'b01, 1'b0},
            '{2'd1, 8'h71, 2'b10, 1'b0}, '{2'd1, 8'h72, 2'b10, 1'b0},
            '{2'd1, 8'h73, 2'b10, 1'b0}, '{2'd1, 8'h74, 2'b10, 1'b1},
            '{2'd1, 8'h75, 2'b10, 1'b1}, '{2'd1, 8'h76, 2'b10, 1'b1},
            '{2'd2, 8'h81, 2'b01, 1'b0}, '{2'd2, 8'h82, 2'b01, 1'b0}
        };

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_grant_%0d", i), 32'(grant[i]), 0);
            chk($sformatf("rst_overrun_%0d", i), 32'(overrun[i]), 0);
        end
        chk("rst_tx_start", 32'(tx_start[0]), 0);
        chk("rst_tx_data", 32'(tx_data[0]), 0);
        chk("rst_ready0", 32'(req_ready[0][0]), 0);
        chk("rst_ready1", 32'(req_ready[0][1]), 0);

        // Tie after reset goes to req0, then req1; next tie goes back to req0.
        src_q[0][0].push_back(9'h011);
        src_q[0][0].push_back(9'h112);
        src_q[0][1].push_back(9'h021);
        src_q[0][1].push_back(9'h122);
        wait_got(0, 4, "tie1_bytes");
        settle();
        src_q[0][0].push_back(9'h131);
        src_q[0][1].push_back(9'h141);
        wait_got(0, 6, "tie2_bytes");
        settle();

        // req0 message "Hi\n": grant one cycle after valid, tx_start one cycle after accept.
        src_q[0][0].push_back(9'h048);
        src_q[0][0].push_back(9'h069);
        src_q[0][0].push_back(9'h10A);
        @(negedge clk);
        chk("t1_ready_idle", 32'(req_ready[0][0]), 0);
        chk("t1_grant_idle", 32'(grant[0]), 0);
        @(negedge clk);
        chk("t1_ready_load", 32'(req_ready[0][0]), 1);
        chk("t1_grant_load", 32'(grant[0]), 32'(2'b01));
        @(negedge clk);
        chk("t1_start_pulse", 32'(tx_start[0]), 1);
        chk("t1_start_data", 32'(tx_data[0]), 32'h48);
        wait_got(0, 9, "t1_bytes");
        t = 0;
        while (grant[0] !== 2'b00 && t < 200) begin
            @(negedge clk);
            t++;
        end
        nz = 0;
        repeat (16) begin
            if (grant[0] !== 2'b00) nz++;
            @(negedge clk);
        end
        chk("t1_gap_grant_zero", 32'(nz), 0);
        settle();

        // req1 arrives during byte 2: waits for byte 3, its 10 busy cycles and a 16-cycle gap.
        src_q[0][0].push_back(9'h051);
        src_q[0][0].push_back(9'h052);
        src_q[0][0].push_back(9'h153);
        wait_got(0, 11, "t3_second_byte");
        src_q[0][1].push_back(9'h161);
        wait_got(0, 13, "t3_bytes");
        chk("t3_gap_spacing", got_q[0][12].cyc - got_q[0][11].cyc, 30);
        settle();

        // MAX_MSG_LEN=4: six bytes split into 4 + 2 with overrun raised at byte 4.
        src_q[1][1].push_back(9'h071);
        src_q[1][1].push_back(9'h072);
        src_q[1][1].push_back(9'h073);
        src_q[1][1].push_back(9'h074);
        src_q[1][1].push_back(9'h075);
        src_q[1][1].push_back(9'h176);
        wait_got(1, 6, "t4_bytes");
        chk("t4_byte_spacing", got_q[1][1].cyc - got_q[1][0].cyc, 13);
        chk("t4_trunc_spacing", got_q[1][4].cyc - got_q[1][3].cyc, 30);
        settle();
        chk("t4_overrun_sticky", 32'(overrun[1]), 1);

        // GAP_CYCLES=0: next grant two cycles after busy falls.
        src_q[2][0].push_back(9'h181);
        src_q[2][0].push_back(9'h182);
        wait_got(2, 1, "t6_first_byte");
        wait_busy(2, 1'b1, "t6_busy_high");
        wait_busy(2, 1'b0, "t6_busy_low");
        @(negedge clk);
        chk("t6_grant_k1", 32'(grant[2]), 0);
        @(negedge clk);
        chk("t6_grant_k2", 32'(grant[2]), 32'(2'b01));
        wait_got(2, 2, "t6_bytes");
        settle();

        // Reset during WAIT_DONE; afterwards the pending byte waits for tx_busy to drop.
        src_q[0][0].push_back(9'h091);
        src_q[0][0].push_back(9'h192);
        wait_got(0, 14, "t5_first_byte");
        wait_busy(0, 1'b1, "t5_busy_high");
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_rst_tx_start", 32'(tx_start[0]), 0);
        chk("t5_rst_grant", 32'(grant[0]), 0);
        chk("t5_rst_tx_data", 32'(tx_data[0]), 0);
        chk("t5_rst_ready0", 32'(req_ready[0][0]), 0);
        chk("t5_rst_ready1", 32'(req_ready[0][1]), 0);
        chk("t5_rst_overrun", 32'(overrun[1]), 0);
        @(negedge clk);
        rst = 1'b0;
        t = 0;
        while (grant[0] !== 2'b01 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("t5_regrant", 32'(grant[0]), 32'(2'b01));
        chk("t5_ready_while_busy", 32'(req_ready[0][0]), 0);
        wait_got(0, 15, "t5_bytes");
        settle();

        for (int k = 0; k < 23; k++) begin
            int i;
            i = int'(vecs[k].inst);
            if (idx[i] < got_q[i].size()) begin
                rec = got_q[i][idx[i]];
                chk($sformatf("vec%0d_data", k), 32'(rec.data), 32'(vecs[k].data));
                chk($sformatf("vec%0d_grant", k), 32'(rec.gnt), 32'(vecs[k].gnt));
                chk($sformatf("vec%0d_overrun", k), 32'(rec.ovr), 32'(vecs[k].ovr));
            end else begin
                checks = checks + 1;
                failures = failures + 1;
                $display("FAIL vec%0d_missing actual=none expected=0x%0h", k, vecs[k].data);
            end
            idx[i] = idx[i] + 1;
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("byte_count_%0d", i), 32'(got_q[i].size()), 32'(idx[i]));
        end
        chk("ready_rule_violations", 32'(bad_ready), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
